// File: rtl/pcpi_result_serializer_if.sv
// Bus bundle between the PCPI result side, the serializer and the host pins.
// The master drives the coprocessor result and the host acknowledge; the slave is the serializer.
interface pcpi_result_serializer_if #(
    parameter int NIBBLES = 8
);
    logic                   pcpi_ready;
    logic                   pcpi_wr;
    logic [4*NIBBLES-1:0]   pcpi_rd;
    logic                   host_ack;
    logic [3:0]             out_nibble;
    logic                   out_valid;
    logic                   out_last;
    logic                   busy;
    logic                   overrun;

    modport master (
        output pcpi_ready, pcpi_wr, pcpi_rd, host_ack,
        input  out_nibble, out_valid, out_last, busy, overrun
    );

    modport slave (
        input  pcpi_ready, pcpi_wr, pcpi_rd, host_ack,
        output out_nibble, out_valid, out_last, busy, overrun
    );
endinterface

// File: rtl/pcpi_result_serializer.sv
// Captures a PCPI write-back result and streams it to a slow host as 4-bit nibbles
// over a 4-phase valid/ack handshake; results arriving mid-transfer are dropped and flagged.
module pcpi_result_serializer #(
    parameter int NIBBLES   = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    pcpi_result_serializer_if.slave       bus
);
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       index_q, index_d;
    logic [4*NIBBLES-1:0]   buffer_q, buffer_d;
    logic                   ack_q;
    logic                   overrun_q, overrun_d;

    logic                   capture;
    logic                   ack_rise;
    logic [IDX_W-1:0]       nib_sel;

    // NOTE: sequential state uses non-blocking assignments only; the buffer is a plain
    // register (not a memory array), so it is cleared by reset along with everything else.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            index_q   <= '0;
            buffer_q  <= '0;
            ack_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            buffer_q  <= buffer_d;
            ack_q     <= bus.host_ack;
            overrun_q <= overrun_d;
        end
    end

    assign capture  = bus.pcpi_ready && bus.pcpi_wr;
    // A level already high when SEND is entered must not count as an acknowledge.
    assign ack_rise = bus.host_ack && !ack_q;

    // NOTE: every variable gets its default first so no path through the case infers a latch.
    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        buffer_d  = buffer_q;
        overrun_d = overrun_q;

        unique case (state_q)
            IDLE: begin
                if (capture) begin
                    buffer_d = bus.pcpi_rd;
                    index_d  = '0;
                    state_d  = SEND;
                end
            end
            SEND: begin
                if (capture) overrun_d = 1'b1;
                if (ack_rise) state_d = RELEASE;
            end
            RELEASE: begin
                if (capture) overrun_d = 1'b1;
                if (!bus.host_ack) begin
                    if (index_q == LAST_IDX) begin
                        index_d = '0;
                        state_d = IDLE;
                    end else begin
                        index_d = index_q + 1'b1;
                        state_d = SEND;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                index_d = '0;
            end
        endcase
    end

    assign nib_sel = LSB_FIRST ? index_q : (LAST_IDX - index_q);

    // Outputs decode registered state only; the nibble reads as zero outside SEND.
    assign bus.out_valid  = (state_q == SEND);
    assign bus.out_nibble = (state_q == SEND) ? buffer_q[{nib_sel, 2'b00} +: 4] : 4'h0;
    assign bus.out_last   = bus.out_valid && (index_q == LAST_IDX);
    assign bus.busy       = (state_q != IDLE);
    assign bus.overrun    = overrun_q;
endmodule
